// File: rtl/display_pkg.sv
// Shared definitions for the display frame arbiter slice.
//   FRAME_W   : frame width in bits (ROWS x COLS, row r in bits [8r+7:8r])
//   SRC_*     : source codes reported on src_active / held with the back buffer
//   arb_state_t : back-buffer occupancy state of the arbiter
package display_pkg;

  localparam int FRAME_W = 64;
  localparam int ROWS    = 8;
  localparam int COLS    = 8;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_A    = 2'b01;
  localparam logic [1:0] SRC_B    = 2'b10;

  // IDLE: back buffer free; PENDING: back buffer holds a frame awaiting swap.
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } arb_state_t;

endpackage

// File: rtl/display_frame_arbiter_rr_arbiter2.sv
// Two-input round-robin grant.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   enable             : grants are only issued while high
//   req_a, req_b       : requests
//   update             : a grant was taken this cycle; remember the winner
//   gnt_a, gnt_b       : one-hot (or zero) combinational grants
// On contention the requester that did not win last time is granted.
// After reset B counts as the last winner, so A wins the first contention.
module rr_arbiter2
  import display_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic enable,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  output logic gnt_a,
  output logic gnt_b
);

  logic [1:0] last_src_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_src_reg <= SRC_B;
    end else if (update) begin
      last_src_reg <= gnt_a ? SRC_A : SRC_B;
    end
  end

  // Grants look only at requests and history, never at request payloads.
  assign gnt_a = enable & req_a & (~req_b | (last_src_reg != SRC_A));
  assign gnt_b = enable & req_b & (~req_a | (last_src_reg == SRC_A));

endmodule

// File: rtl/display_frame_arbiter.sv
// Double-buffered frame arbiter in front of the 8x8 74HC595 scan driver.
//   sys_clk, sys_rst_n     : clock, asynchronous active-low reset
//   a_valid/a_data/a_ready : producer A frame handshake
//   b_valid/b_data/b_ready : producer B frame handshake
//   frame_done             : one-cycle pulse from the scan driver after row 7
//   frame_out              : front buffer, drives the scan driver frame input
//   src_active             : source of the front buffer (none / A / B)
//   swap_pulse             : high for one cycle after each front/back swap
// A frame is accepted into the back buffer only while it is free. It moves to
// the front only on a frame_done edge and only once the current front frame
// has been shown for HOLD_FRAMES complete scans, so no torn frame is shown.
module display_frame_arbiter #(
  parameter int HOLD_FRAMES = 8,
  parameter int FRAME_W     = 64
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               a_valid,
  input  logic [FRAME_W-1:0] a_data,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [FRAME_W-1:0] b_data,
  output logic               b_ready,
  input  logic               frame_done,
  output logic [FRAME_W-1:0] frame_out,
  output logic [1:0]         src_active,
  output logic               swap_pulse
);
  import display_pkg::*;

  localparam int             HC_W     = $clog2(HOLD_FRAMES + 1);
  // One extra bit so hold_cnt + 1 never wraps before the comparison.
  localparam logic [HC_W:0]  HOLD_EXT = (HC_W + 1)'(HOLD_FRAMES);
  localparam logic [HC_W:0]  ONE_EXT  = (HC_W + 1)'(1);

  arb_state_t          state_reg;
  arb_state_t          state_next;

  logic [FRAME_W-1:0]  back_reg;
  logic [1:0]          back_src_reg;
  logic [FRAME_W-1:0]  frame_out_reg;
  logic [1:0]          src_active_reg;
  logic                swap_pulse_reg;
  logic [HC_W-1:0]     hold_cnt_reg;

  logic [HC_W:0]       hold_inc;
  logic                hold_met;
  logic [HC_W-1:0]     hold_sat;
  logic                a_accept;
  logic                b_accept;
  logic                accept;
  logic                swap;

  // ---------------------------------------------------------------------------
  // Grant: only while the back buffer is free.
  // ---------------------------------------------------------------------------
  rr_arbiter2 u_rr_arbiter2 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable    (state_reg == IDLE),
    .req_a     (a_valid),
    .req_b     (b_valid),
    .update    (accept),
    .gnt_a     (a_ready),
    .gnt_b     (b_ready)
  );

  assign a_accept = a_valid & a_ready;
  assign b_accept = b_valid & b_ready;
  assign accept   = a_accept | b_accept;

  // ---------------------------------------------------------------------------
  // Hold counter arithmetic. hold_cnt counts completed scans of the current
  // front frame, saturating at HOLD_FRAMES; the frame_done that completes the
  // HOLD_FRAMES-th scan is the earliest one allowed to swap.
  // ---------------------------------------------------------------------------
  assign hold_inc = {1'b0, hold_cnt_reg} + ONE_EXT;
  assign hold_met = (hold_inc >= HOLD_EXT);
  assign hold_sat = hold_met ? HOLD_EXT[HC_W-1:0] : hold_inc[HC_W-1:0];
  assign swap     = frame_done & (state_reg == PENDING) & hold_met;

  // ---------------------------------------------------------------------------
  // Back-buffer occupancy FSM. Accept only happens in IDLE and swap only in
  // PENDING, so the two can never collide.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = PENDING;
      PENDING: if (swap)   state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Buffers, front-buffer outputs and hold counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      back_reg       <= '0;
      back_src_reg   <= SRC_NONE;
      frame_out_reg  <= '0;
      src_active_reg <= SRC_NONE;
      swap_pulse_reg <= 1'b0;
      // Start saturated so the first frame after reset shows at once.
      hold_cnt_reg   <= HOLD_EXT[HC_W-1:0];
    end else begin
      swap_pulse_reg <= swap;

      if (a_accept) begin
        back_reg     <= a_data;
        back_src_reg <= SRC_A;
      end else if (b_accept) begin
        back_reg     <= b_data;
        back_src_reg <= SRC_B;
      end

      if (swap) begin
        frame_out_reg  <= back_reg;
        src_active_reg <= back_src_reg;
      end

      if (frame_done) begin
        hold_cnt_reg <= swap ? '0 : hold_sat;
      end
    end
  end

  assign frame_out  = frame_out_reg;
  assign src_active = src_active_reg;
  assign swap_pulse = swap_pulse_reg;

endmodule

// File: tb/tb_display_frame_arbiter.sv
// Self-checking bench for display_frame_arbiter. A queue-based reference model
// tracks the back buffer, displayed frame and scans shown since the last swap.
module tb_display_frame_arbiter;
  import display_pkg::*;

  localparam int HOLD = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic [63:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [63:0] b_data = '0;
  logic        b_ready;
  logic        frame_done = 1'b0;
  logic [63:0] frame_out;
  logic [1:0]  src_active;
  logic        swap_pulse;

  always #5 sys_clk = ~sys_clk;

  display_frame_arbiter #(.HOLD_FRAMES(HOLD), .FRAME_W(64)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .a_valid    (a_valid),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .frame_done (frame_done),
    .frame_out  (frame_out),
    .src_active (src_active),
    .swap_pulse (swap_pulse)
  );

  // frame_done must be a single-cycle pulse.
  assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
                   !(frame_done && $past(frame_done)));

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [63:0] back_q[$];
  logic [1:0]  back_src_q[$];
  logic [63:0] m_front;
  logic [1:0]  m_src;
  logic        m_pulse;
  logic        m_last_b;
  int          m_shown;
  int          fd_since_swap;
  int          gaps[$];
  logic [1:0]  grants[$];
  logic        seen_a_ready;
  logic        seen_b_ready;

  logic [63:0] rd_a;
  logic [63:0] rd_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    back_q.delete();
    back_src_q.delete();
    m_front       = '0;
    m_src         = SRC_NONE;
    m_pulse       = 1'b0;
    m_last_b      = 1'b1;
    m_shown       = HOLD;
    fd_since_swap = 0;
  endtask

  // Called just after a falling edge: checks registered outputs, applies the
  // inputs, checks readies, then advances the model over the next rising edge.
  task automatic cycle(input logic av, input logic [63:0] ad,
                       input logic bv, input logic [63:0] bd, input logic fd);
    logic pend, exp_ar, exp_br, swap_now;
    chk("frame_out", frame_out, m_front);
    chk("src_active", 64'(src_active), 64'(m_src));
    chk("swap_pulse", 64'(swap_pulse), 64'(m_pulse));
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; frame_done = fd;
    #1;
    pend   = (back_q.size() != 0);
    exp_ar = !pend && av && (!bv || m_last_b);
    exp_br = !pend && bv && (!av || !m_last_b);
    chk("a_ready", 64'(a_ready), 64'(exp_ar));
    chk("b_ready", 64'(b_ready), 64'(exp_br));
    seen_a_ready = a_ready;
    seen_b_ready = b_ready;
    swap_now = fd && pend && (m_shown + 1 >= HOLD);
    @(posedge sys_clk);
    m_pulse = swap_now;
    if (fd) begin
      fd_since_swap++;
      if (swap_now) begin
        gaps.push_back(fd_since_swap);
        fd_since_swap = 0;
        m_shown = 0;
        m_front = back_q.pop_front();
        m_src   = back_src_q.pop_front();
      end else begin
        m_shown = (m_shown + 1 > HOLD) ? HOLD : m_shown + 1;
      end
    end
    if (exp_ar) begin
      back_q.push_back(ad); back_src_q.push_back(SRC_A);
      m_last_b = 1'b0; grants.push_back(SRC_A);
    end else if (exp_br) begin
      back_q.push_back(bd); back_src_q.push_back(SRC_B);
      m_last_b = 1'b1; grants.push_back(SRC_B);
    end
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; frame_done = 1'b0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic last_fd, fd;
    model_reset();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Phase 1: no requests, three frame_done pulses
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0, '0, 1'b1);
      idle(2);
    end
    chk("p1_frame_out", frame_out, 64'h0);
    chk("p1_src", 64'(src_active), 64'h0);

    // Phase 2: first A frame shows on the first frame_done
    cycle(1'b1, 64'h0000_0000_0000_00FF, 1'b0, '0, 1'b0);
    chk("p2_a_ready", 64'(seen_a_ready), 64'h1);
    idle(1);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    chk("p2_frame_out", frame_out, 64'h0000_0000_0000_00FF);
    chk("p2_src", 64'(src_active), 64'h1);
    chk("p2_pulse_hi", 64'(swap_pulse), 64'h1);
    idle(1);
    chk("p2_pulse_lo", 64'(swap_pulse), 64'h0);

    // Phase 3: both valid continuously, alternation and 8-frame spacing
    do_reset();
    grants.delete(); gaps.delete();
    k = 0;
    while (gaps.size() < 3 && k < 400) begin
      cycle(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'h5555_5555_5555_5555, (k % 4) == 3);
      k++;
    end
    chk("p3_swaps_seen", 64'(gaps.size()), 64'd3);
    if (gaps.size() >= 3 && grants.size() >= 3) begin
      chk("p3_grant0", 64'(grants[0]), 64'(SRC_A));
      chk("p3_grant1", 64'(grants[1]), 64'(SRC_B));
      chk("p3_grant2", 64'(grants[2]), 64'(SRC_A));
      chk("p3_gap1", 64'(gaps[1]), 64'd8);
      chk("p3_gap2", 64'(gaps[2]), 64'd8);
    end
    chk("p3_grant_count", 64'(grants.size()), 64'd3);

    // Phase 4/5: B accepted two frames after a swap, A held valid while pending
    gaps.delete();
    idle(1); cycle(1'b0, '0, 1'b0, '0, 1'b1);
    idle(1); cycle(1'b0, '0, 1'b0, '0, 1'b1);
    rd_b = {$urandom, $urandom};
    rd_a = {$urandom, $urandom};
    cycle(1'b0, '0, 1'b1, rd_b, 1'b0);
    chk("p4_b_ready", 64'(seen_b_ready), 64'h1);
    k = 0;
    while (gaps.size() == 0 && k < 200) begin
      cycle(1'b1, rd_a, 1'b0, '0, (k % 3) == 2);
      chk("p5_a_ready_low", 64'(seen_a_ready), 64'h0);
      k++;
    end
    chk("p4_swap_seen", 64'(gaps.size()), 64'd1);
    if (gaps.size() > 0) chk("p4_gap", 64'(gaps[0]), 64'd8);
    chk("p4_frame_out", frame_out, rd_b);
    chk("p4_src", 64'(src_active), 64'(SRC_B));
    cycle(1'b1, rd_a, 1'b0, '0, 1'b0);
    chk("p5_a_ready_after", 64'(seen_a_ready), 64'h1);
    idle(2);

    // Phase 6: random traffic
    last_fd = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      fd = !last_fd && ($urandom_range(2) == 0);
      cycle($urandom_range(1) == 1, {$urandom, $urandom},
            $urandom_range(1) == 1, {$urandom, $urandom}, fd);
      last_fd = fd;
    end

    // Phase 7: asynchronous reset while a frame is pending
    do_reset();
    rd_a = {$urandom, $urandom} | 64'h1;
    rd_b = {$urandom, $urandom};
    cycle(1'b1, rd_a, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    idle(1);
    chk("p7_frame_before", frame_out, rd_a);
    cycle(1'b0, '0, 1'b1, rd_b, 1'b0);
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("p7_async_frame", frame_out, 64'h0);
    chk("p7_async_src", 64'(src_active), 64'h0);
    model_reset();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle(1);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    chk("p7_no_swap", 64'(swap_pulse), 64'h0);
    chk("p7_frame_blank", frame_out, 64'h0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_frame_arbiter.md
Name: display_frame_arbiter

Overview:
- Sits upstream of the 74HC595 8x8 scan driver and owns that driver's 64-bit frame input.
- Arbitrates round-robin between two frame producers (A, B) over valid/ready handshakes.
- Double-buffers the frame: a front buffer is being scanned, a back buffer is pending.
- Swaps only at scan-frame boundaries, and only after a minimum display time, so the matrix never shows a torn frame.

Parameters:
- HOLD_FRAMES, 8, minimum number of completed scan frames a front buffer is shown before the next swap; legal range 1..255.
- FRAME_W, 64, frame width in bits (8 rows x 8 columns, row r in bits [8r+7:8r]).

Ports:
- sys_clk  in  1  system clock; all state changes on the rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- a_valid  in  1  producer A offers a frame.
- a_data  in  FRAME_W  producer A frame.
- a_ready  out  1  A transfer occurs when a_valid & a_ready are high at a clock edge.
- b_valid  in  1  producer B offers a frame.
- b_data  in  FRAME_W  producer B frame.
- b_ready  out  1  B handshake, same rules as A.
- frame_done  in  1  one-cycle pulse from the scan driver after the row-7 latch.
- frame_out  out  FRAME_W  front buffer; drives the scan driver's frame input.
- src_active  out  2  source of the front buffer: 00 = none (blank), 01 = A, 10 = B.
- swap_pulse  out  1  one-cycle pulse in the cycle after a swap edge.

Behaviour:
- Reset values (async assert, sync release):
  - frame_out = 0, src_active = 00, swap_pulse = 0.
  - pending = 0, back = 0, back_src = 00.
  - hold_cnt = HOLD_FRAMES (saturated), last_grant = B.
- States:
  - IDLE (pending = 0): back buffer free.
  - PENDING (pending = 1): back buffer holds a frame awaiting swap.
- Grant logic (combinational from registered state and valids):
  - In PENDING: a_ready = b_ready = 0.
  - In IDLE with one valid: that requester's ready = 1.
  - In IDLE with both valid: the requester that is not last_grant gets ready; the other gets 0.
  - ready never depends on the requester's own data.
- Accept edge (valid & ready):
  - back <= data, back_src <= requester code, last_grant <= requester, go to PENDING.
  - Only one acceptance per cycle.
- hold_cnt: on every frame_done, hold_cnt <= min(hold_cnt + 1, HOLD_FRAMES); width clog2(HOLD_FRAMES + 1).
- Swap condition, evaluated on a frame_done edge: pending & (hold_cnt + 1 >= HOLD_FRAMES).
- Swap edge:
  - frame_out <= back, src_active <= back_src.
  - pending <= 0, hold_cnt <= 0.
  - swap_pulse <= 1 for exactly one cycle.
- frame_done while PENDING but hold not met: count only, no swap.
- frame_done while IDLE: count only; frame_out unchanged, so the last frame repeats indefinitely.
- Simultaneous cases:
  - Accept and swap cannot coincide, because ready = 0 in PENDING.
  - A requester asserting valid in the swap cycle sees ready = 1 the following cycle.
- First frame after reset swaps at the first frame_done, because hold_cnt starts saturated.
- HOLD_FRAMES = 1: every frame_done swaps a pending frame.
- Latency:
  - Accept to frame_out: at least until the next frame_done edge that meets the hold condition.
  - Swap to frame_out valid: 0 cycles after the edge (registered output).
- Reset mid-operation: pending frame discarded, display blanks immediately (frame_out = 0).
- frame_done pulses wider than one cycle are a protocol error and count once per cycle. The bench asserts that this never happens.

Decomposition:
- Shared package display_pkg holds:
  - FRAME_W, ROWS = 8, COLS = 8.
  - Source codes SRC_NONE = 2'b00, SRC_A = 2'b01, SRC_B = 2'b10.
  - The arbiter state enum {IDLE, PENDING}.
- One natural sub-module, rr_arbiter2: a two-input round-robin grant with last_grant register, update enable, and clear on reset.
- Buffers, hold counter and swap logic stay in the top module.

Test Plan:
- Reset release, no requests, 3 frame_done pulses -> frame_out = 0, src_active = 00, swap_pulse never high.
- A offers 64'h0000_0000_0000_00FF, HOLD_FRAMES = 8:
  - a_ready = 1, accepted in 1 cycle.
  - First frame_done -> frame_out = 64'hFF, src_active = 01, one-cycle swap_pulse.
- A and B both valid continuously (A = 64'hAAAA..., B = 64'h5555...):
  - Grants alternate A, B, A.
  - Each swap occurs exactly 8 frame_done pulses after the previous swap.
  - Neither requester starves.
- B accepted 2 frames after a swap -> no swap on frame_done numbers 3..7; swap on frame_done #8; frame_out = B data.
- PENDING state with a_valid held high -> a_ready = 0 until the cycle after swap, then 1; the new data is accepted that cycle.
- sys_rst_n pulsed low mid-PENDING, asynchronously between clock edges:
  - frame_out = 0 immediately, pending cleared.
  - After release, first frame_done with no new request -> no swap.
